// File: rtl/pwm_capture.sv
// pwm_capture
//   Input-capture block for an external PWM/pulse signal. Measures the high
//   time and the period (rising edge to rising edge) in clock cycles. It then
//   converts them into an 8-bit duty value on the same scale as the
//   pwm_generator duty_cycle input: min(255, floor(high*256/period)).
//   A line that shows no rising edge for TIMEOUT cycles is reported as stuck.
//   In that case duty reads 0 or 255 depending on the static level.
//
// Parameters
//   CNT_W    width of the high-time / period counters and result registers
//   TIMEOUT  cycles without a rising edge before stuck is declared
//            (2 <= TIMEOUT <= 2^CNT_W-1, so the counters never wrap)
//
// Ports
//   clock       system clock, all state on posedge
//   reset       asynchronous, active-high, clears all state
//   pwm_in      external signal, asynchronous to clock
//   high_cnt    high time of the last complete period
//   period_cnt  last complete period
//   duty        8-bit duty, 0/255 when stuck
//   valid       one-cycle pulse when duty/stuck are updated
//   busy        divider running
//   stuck       no rising edge within TIMEOUT cycles
//   irq/irq_clr sticky interrupt and its clear, only when the macro
//               PWM_CAPTURE_IRQ_EN is defined
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [7:0]       duty,
  output logic             valid,
  output logic             busy,
  output logic             stuck
`ifdef PWM_CAPTURE_IRQ_EN
  ,
  output logic             irq,
  input  logic             irq_clr
`endif
);

  localparam int               DW        = CNT_W + 8;
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_V     = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  logic             sync_a_r;
  logic             sync_b_r;
  logic             sync_d_r;
  logic             rise_s;
  logic             timeout_s;
  logic             latch_s;
  logic             fin_s;
  logic             report_s;
  logic [CNT_W-1:0] run_cnt_r;
  logic [CNT_W-1:0] high_run_r;
  logic             armed_r;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [DW-1:0]    rem_r;
  logic [DW-1:0]    div_r;
  logic [8:0]       quot_r;
  logic [3:0]       iter_r;
  logic             ge_s;
  logic [7:0]       duty_div_s;

  assign rise_s    = sync_b_r & ~sync_d_r;
  // A rise in the same cycle as the timeout wins.
  assign timeout_s = (run_cnt_r == TIMEOUT_V) & ~rise_s;
  assign latch_s   = rise_s & armed_r;
  // A rise in the finishing cycle relatches and discards the old quotient.
  assign fin_s     = (state_r == ST_FIN) & ~latch_s & ~timeout_s;
  assign report_s  = timeout_s | fin_s;
  assign ge_s      = (rem_r >= div_r);
  // The quotient reaches 256 only when high == period.
  assign duty_div_s = quot_r[8] ? 8'hFF : quot_r[7:0];

  // Two-flop synchroniser followed by the edge-detect flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a_r <= 1'b0;
      sync_b_r <= 1'b0;
      sync_d_r <= 1'b0;
    end else begin
      sync_a_r <= pwm_in;
      sync_b_r <= sync_a_r;
      sync_d_r <= sync_b_r;
    end
  end

  // Free-running period counter, high-time counter and arm flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_cnt_r  <= '0;
      high_run_r <= '0;
      armed_r    <= 1'b0;
    end else if (rise_s) begin
      run_cnt_r  <= ONE_V;
      high_run_r <= ONE_V;
      armed_r    <= 1'b1;
    end else if (timeout_s) begin
      run_cnt_r  <= ONE_V;
      // Keeps high_run from wrapping on a line stuck high. The block is
      // disarmed, so the next rise reloads it before it is ever used.
      high_run_r <= '0;
      armed_r    <= 1'b0;
    end else begin
      run_cnt_r  <= run_cnt_r + ONE_V;
      high_run_r <= sync_b_r ? (high_run_r + ONE_V) : high_run_r;
    end
  end

  // Measurement registers: latched on an armed rise, cleared on timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      high_cnt   <= '0;
      period_cnt <= '0;
    end else if (latch_s) begin
      high_cnt   <= high_run_r;
      period_cnt <= run_cnt_r;
    end else if (timeout_s) begin
      high_cnt   <= '0;
      period_cnt <= '0;
    end
  end

  // Divider state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Divider next state: timeout aborts, an armed rise (re)starts.
  always_comb begin
    state_nxt_s = state_r;
    if (timeout_s) begin
      state_nxt_s = ST_IDLE;
    end else if (latch_s) begin
      state_nxt_s = ST_DIV;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_IDLE;
        ST_DIV: begin
          if (iter_r == 4'd8) begin
            state_nxt_s = ST_FIN;
          end else begin
            state_nxt_s = ST_DIV;
          end
        end
        ST_FIN:  state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Restoring divider datapath. Because high <= period, the quotient fits
  // in 9 bits. That is why the divisor starts shifted left by 8 and only
  // 9 trial subtractions are needed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem_r  <= '0;
      div_r  <= '0;
      quot_r <= 9'd0;
      iter_r <= 4'd0;
    end else if (latch_s) begin
      rem_r  <= {high_run_r, 8'h00};
      div_r  <= {run_cnt_r, 8'h00};
      quot_r <= 9'd0;
      iter_r <= 4'd0;
    end else if (state_r == ST_DIV) begin
      if (ge_s) begin
        rem_r <= rem_r - div_r;
      end
      quot_r <= {quot_r[7:0], ge_s};
      div_r  <= div_r >> 1;
      iter_r <= iter_r + 4'd1;
    end
  end

  // Result, status and handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      duty  <= 8'h00;
      stuck <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      valid <= report_s;
      busy  <= (state_nxt_s == ST_DIV);
      if (timeout_s) begin
        duty  <= sync_b_r ? 8'hFF : 8'h00;
        stuck <= 1'b1;
      end else if (fin_s) begin
        duty  <= duty_div_s;
        stuck <= 1'b0;
      end
    end
  end

`ifdef PWM_CAPTURE_IRQ_EN
  // Sticky interrupt: set on every report, a same-cycle clear loses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (report_s) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 300;

  logic             clock = 1'b0;
  logic             reset;
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [7:0]       duty;
  logic             valid;
  logic             busy;
  logic             stuck;
`ifdef PWM_CAPTURE_IRQ_EN
  logic             irq;
  logic             irq_clr;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int busy_ticks = 0;

  // log of every valid pulse seen by tick()
  int         v_cyc[$];
  logic [7:0] v_duty[$];
  logic [15:0] v_hc[$];
  logic [15:0] v_pc[$];
  logic       v_stuck[$];

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .duty       (duty),
    .valid      (valid),
    .busy       (busy),
    .stuck      (stuck)
`ifdef PWM_CAPTURE_IRQ_EN
    ,
    .irq        (irq),
    .irq_clr    (irq_clr)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (busy === 1'b1) busy_ticks++;
    if (valid === 1'b1) begin
      v_cyc.push_back(cyc);
      v_duty.push_back(duty);
      v_hc.push_back(high_cnt);
      v_pc.push_back(period_cnt);
      v_stuck.push_back(stuck);
    end
  endtask

  task automatic clear_log();
    v_cyc.delete();
    v_duty.delete();
    v_hc.delete();
    v_pc.delete();
    v_stuck.delete();
    busy_ticks = 0;
  endtask

  task automatic apply_reset();
    reset  = 1'b1;
    pwm_in = 1'b0;
`ifdef PWM_CAPTURE_IRQ_EN
    irq_clr = 1'b0;
`endif
    repeat (2) tick();
    reset = 1'b0;
    clear_log();
  endtask

  // n periods of p cycles, high for the first h cycles of each
  task automatic wave(input int h, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      pwm_in = 1'b1;
      repeat (h) tick();
      pwm_in = 1'b0;
      repeat (p - h) tick();
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    pwm_in = 1'b1;
`ifdef PWM_CAPTURE_IRQ_EN
    irq_clr = 1'b0;
`endif
    repeat (3) tick();
    checks++; if (high_cnt !== 16'd0)   begin errors++; $display("FAIL reset_high: got %0d want 0", high_cnt); end
    checks++; if (period_cnt !== 16'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", period_cnt); end
    checks++; if (duty !== 8'd0)        begin errors++; $display("FAIL reset_duty: got %0d want 0", duty); end
    checks++; if (valid !== 1'b0)       begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (stuck !== 1'b0)       begin errors++; $display("FAIL reset_stuck: got %b want 0", stuck); end
`ifdef PWM_CAPTURE_IRQ_EN
    checks++; if (irq !== 1'b0)         begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
  endtask

  // period 256, high 64: first rise arms, later rises latch, valid 10 cycles after the latch
  task automatic test_basic();
    int c0;
    apply_reset();
    c0 = cyc;
    wave(64, 256, 3);
    repeat (10) tick();
    checks++; if (v_cyc.size() !== 2) begin errors++; $display("FAIL basic_count: got %0d valids want 2", v_cyc.size()); end
    if (v_cyc.size() >= 1) begin
      checks++;
      if ({v_cyc[0] - c0, v_duty[0], v_hc[0], v_pc[0], v_stuck[0]} !== {32'd269, 8'd64, 16'd64, 16'd256, 1'b0}) begin
        errors++;
        $display("FAIL basic_v0: got cyc=%0d duty=%0d high=%0d period=%0d stuck=%0b want cyc=269 duty=64 high=64 period=256 stuck=0",
                 v_cyc[0] - c0, v_duty[0], v_hc[0], v_pc[0], v_stuck[0]);
      end
    end
    if (v_cyc.size() >= 2) begin
      checks++;
      if ({v_cyc[1] - c0, v_duty[1], v_hc[1], v_pc[1]} !== {32'd525, 8'd64, 16'd64, 16'd256}) begin
        errors++;
        $display("FAIL basic_v1: got cyc=%0d duty=%0d high=%0d period=%0d want cyc=525 duty=64 high=64 period=256",
                 v_cyc[1] - c0, v_duty[1], v_hc[1], v_pc[1]);
      end
    end
    checks++; if (busy_ticks !== 18) begin errors++; $display("FAIL basic_busy: got %0d busy cycles want 18", busy_ticks); end
  endtask

  // one 50/100 period, then line held high: 255 stuck reports every TIMEOUT cycles
  task automatic test_stuck_high();
    int c0;
    apply_reset();
    c0 = cyc;
    wave(50, 100, 1);
    pwm_in = 1'b1;
    repeat (620) tick();
    checks++; if (v_cyc.size() !== 3) begin errors++; $display("FAIL high_count: got %0d valids want 3", v_cyc.size()); end
    if (v_cyc.size() >= 1) begin
      checks++;
      if ({v_cyc[0] - c0, v_duty[0], v_stuck[0]} !== {32'd113, 8'd128, 1'b0}) begin
        errors++;
        $display("FAIL high_v0: got cyc=%0d duty=%0d stuck=%0b want cyc=113 duty=128 stuck=0", v_cyc[0] - c0, v_duty[0], v_stuck[0]);
      end
    end
    if (v_cyc.size() >= 2) begin
      checks++;
      if ({v_cyc[1] - c0, v_duty[1], v_hc[1], v_pc[1], v_stuck[1]} !== {32'd403, 8'd255, 16'd0, 16'd0, 1'b1}) begin
        errors++;
        $display("FAIL high_v1: got cyc=%0d duty=%0d high=%0d period=%0d stuck=%0b want cyc=403 duty=255 high=0 period=0 stuck=1",
                 v_cyc[1] - c0, v_duty[1], v_hc[1], v_pc[1], v_stuck[1]);
      end
    end
    if (v_cyc.size() >= 3) begin
      checks++;
      if ({v_cyc[2] - c0, v_duty[2], v_stuck[2]} !== {32'd703, 8'd255, 1'b1}) begin
        errors++;
        $display("FAIL high_v2: got cyc=%0d duty=%0d stuck=%0b want cyc=703 duty=255 stuck=1", v_cyc[2] - c0, v_duty[2], v_stuck[2]);
      end
    end
  endtask

  // line low from reset: stuck with duty 0, first rise only arms, second measures
  task automatic test_stuck_low();
    int c0;
    int c1;
    apply_reset();
    c0 = cyc;
    repeat (310) tick();
    c1 = cyc;
    pwm_in = 1'b1;
    repeat (10) tick();
    checks++; if (stuck !== 1'b1) begin errors++; $display("FAIL low_arm_keeps_stuck: got %b want 1", stuck); end
    repeat (10) tick();
    pwm_in = 1'b0;
    repeat (60) tick();
    wave(20, 80, 1);
    checks++; if (v_cyc.size() !== 2) begin errors++; $display("FAIL low_count: got %0d valids want 2", v_cyc.size()); end
    if (v_cyc.size() >= 1) begin
      checks++;
      if ({v_cyc[0] - c0, v_duty[0], v_stuck[0]} !== {32'd301, 8'd0, 1'b1}) begin
        errors++;
        $display("FAIL low_v0: got cyc=%0d duty=%0d stuck=%0b want cyc=301 duty=0 stuck=1", v_cyc[0] - c0, v_duty[0], v_stuck[0]);
      end
    end
    if (v_cyc.size() >= 2) begin
      checks++;
      if ({v_cyc[1] - c1, v_duty[1], v_hc[1], v_pc[1], v_stuck[1]} !== {32'd93, 8'd64, 16'd20, 16'd80, 1'b0}) begin
        errors++;
        $display("FAIL low_v1: got cyc=%0d duty=%0d high=%0d period=%0d stuck=%0b want cyc=93 duty=64 high=20 period=80 stuck=0",
                 v_cyc[1] - c1, v_duty[1], v_hc[1], v_pc[1], v_stuck[1]);
      end
    end
  endtask

  // 3/8 train keeps restarting the divider. Its last closed period
  // (measured at the first long rise) completes as 96, then 10/40 gives 64.
  task automatic test_back_to_back();
    int c0;
    apply_reset();
    c0 = cyc;
    wave(3, 8, 6);
    checks++; if (v_cyc.size() !== 0) begin errors++; $display("FAIL b2b_short_train: got %0d valids want 0", v_cyc.size()); end
    wave(10, 40, 2);
    checks++; if (v_cyc.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d valids want 2", v_cyc.size()); end
    if (v_cyc.size() >= 1) begin
      checks++;
      if ({v_cyc[0] - c0, v_duty[0], v_hc[0], v_pc[0]} !== {32'd61, 8'd96, 16'd3, 16'd8}) begin
        errors++;
        $display("FAIL b2b_v0: got cyc=%0d duty=%0d high=%0d period=%0d want cyc=61 duty=96 high=3 period=8",
                 v_cyc[0] - c0, v_duty[0], v_hc[0], v_pc[0]);
      end
    end
    if (v_cyc.size() >= 2) begin
      checks++;
      if ({v_cyc[1] - c0, v_duty[1], v_hc[1], v_pc[1]} !== {32'd101, 8'd64, 16'd10, 16'd40}) begin
        errors++;
        $display("FAIL b2b_v1: got cyc=%0d duty=%0d high=%0d period=%0d want cyc=101 duty=64 high=10 period=40",
                 v_cyc[1] - c0, v_duty[1], v_hc[1], v_pc[1]);
      end
    end
  endtask

  // reset 4 cycles into a divide: immediate clear, then the next rise only arms
  task automatic test_reset_mid_divide();
    int c2;
    apply_reset();
    pwm_in = 1'b1;
    repeat (64) tick();
    pwm_in = 1'b0;
    repeat (192) tick();
    pwm_in = 1'b1;
    repeat (7) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstdiv_busy_before: got %b want 1", busy); end
    reset  = 1'b1;
    pwm_in = 1'b0;
    #1;
    checks++;
    if ({high_cnt, period_cnt, duty, valid, busy, stuck} !== {16'd0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rstdiv_clear: got high=%0d period=%0d duty=%0d valid=%b busy=%b stuck=%b want all 0",
               high_cnt, period_cnt, duty, valid, busy, stuck);
    end
    repeat (2) tick();
    reset = 1'b0;
    clear_log();
    c2 = cyc;
    wave(30, 120, 2);
    checks++; if (v_cyc.size() !== 1) begin errors++; $display("FAIL rstdiv_count: got %0d valids want 1", v_cyc.size()); end
    if (v_cyc.size() >= 1) begin
      checks++;
      if ({v_cyc[0] - c2, v_duty[0], v_hc[0], v_pc[0]} !== {32'd133, 8'd64, 16'd30, 16'd120}) begin
        errors++;
        $display("FAIL rstdiv_v0: got cyc=%0d duty=%0d high=%0d period=%0d want cyc=133 duty=64 high=30 period=120",
                 v_cyc[0] - c2, v_duty[0], v_hc[0], v_pc[0]);
      end
    end
  endtask

`ifdef PWM_CAPTURE_IRQ_EN
  // irq sets with valid, survives a coincident clear, drops on a lone clear
  task automatic test_irq();
    int c0;
    int t;
    apply_reset();
    c0 = cyc;
    for (int k = 0; k < 540; k++) begin
      t = cyc - c0;
      pwm_in  = ((t % 256) < 64) ? 1'b1 : 1'b0;
      irq_clr = (t == 524 || t == 530) ? 1'b1 : 1'b0;
      tick();
      t = cyc - c0;
      if (t == 268) begin
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before: got %b want 0", irq); end
      end
      if (t == 269) begin
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq); end
      end
      if (t == 400) begin
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b want 1", irq); end
      end
      if (t == 525) begin
        checks++;
        if ({valid, irq} !== 2'b11) begin
          errors++;
          $display("FAIL irq_set_wins: got valid=%b irq=%b want valid=1 irq=1", valid, irq);
        end
      end
      if (t == 531) begin
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
      end
    end
    irq_clr = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stuck_high();
    test_stuck_low();
    test_back_to_back();
    test_reset_mid_divide();
`ifdef PWM_CAPTURE_IRQ_EN
    test_irq();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
